pipeline_stall_ctrl: RTL and testbench

Hazard and stall controller for the five-stage MIPS pipeline. Every cycle it decides whether the instruction in D may advance into the ID_EX register, or whether F/D freeze and ID_EX loads a bubble. It also owns the multi-cycle multiply/divide busy timer that serialises HI/LO users, and a saturating stall-cycle counter for performance checks.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 39 +++
 rtl/pipeline_stall_ctrl_md_busy_timer.sv | 62 ++++++
 rtl/pipeline_stall_ctrl.sv | 83 ++++++++
 tb/tb_pipeline_stall_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_ctrl_pkg
// Description : Shared constants, types and hazard helper for the stall ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_stall_ctrl_pkg;

    localparam logic [1:0]  TUSE_NONE       = 2'd3;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int          MD_COUNT_W      = 4;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // An operand stalls when a pending producer will not have its result
    // forwardable by the time D consumes it; $0 and unused operands never do.
    function automatic logic operand_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_wreg,
        input logic [1:0] e_tnew,
        input logic [4:0] m_wreg,
        input logic [1:0] m_tnew
    );
        logic hit;
        hit = 1'b0;
        if ((src != 5'd0) && (tuse != TUSE_NONE)) begin
            if ((src == e_wreg) && (e_tnew > tuse)) hit = 1'b1;
            if ((src == m_wreg) && (m_tnew > tuse)) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_stall_ctrl_md_busy_timer.sv
`default_nettype none
// ============================================================================
// Module      : md_busy_timer
// Description : Multiply/divide busy countdown that serialises HI/LO users.
// Revision    : 1.0 - initial release
// ============================================================================
module md_busy_timer
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  is_div,
    output logic                  busy,
    output logic [MD_COUNT_W-1:0] count
);

    generate
        if ((DIV_CYCLES > 15) || (MULT_CYCLES > 15) ||
            (DIV_CYCLES == 0) || (MULT_CYCLES == 0)) begin : g_bad_cycles
            $error("md_busy_timer: MULT_CYCLES/DIV_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [MD_COUNT_W-1:0] MULT_LOAD = MD_COUNT_W'(MULT_CYCLES);
    localparam logic [MD_COUNT_W-1:0] DIV_LOAD  = MD_COUNT_W'(DIV_CYCLES);
    localparam logic [MD_COUNT_W-1:0] ONE       = MD_COUNT_W'(1);

    md_state_e             state_q, state_d;
    logic [MD_COUNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // A start while already busy simply reloads; the pipeline never does it.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (start) begin
            count_d = is_div ? DIV_LOAD : MULT_LOAD;
            state_d = MD_BUSY;
        end else if (state_q == MD_BUSY) begin
            count_d = count_q - ONE;
            if (count_q == ONE) state_d = MD_IDLE;
        end
    end

    assign busy  = (state_q == MD_BUSY);
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_ctrl
// Description : D-stage hazard detection, stall/flush generation, md timer.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic        d_is_md,
    input  logic [4:0]  e_wreg,
    input  logic [4:0]  m_wreg,
    input  logic [1:0]  e_tnew,
    input  logic [1:0]  m_tnew,
    input  logic        e_md_start,
    input  logic        e_md_is_div,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_e,
    output logic        md_busy,
    output logic [3:0]  md_count,
    output logic [31:0] stall_cycles
);

    logic        w_stall_rs;
    logic        w_stall_rt;
    logic        w_stall_md;
    logic        w_stall;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (e_md_start),
        .is_div (e_md_is_div),
        .busy   (md_busy),
        .count  (md_count)
    );

    // e_md_start is included so a HI/LO user behind a just-issued mult/div
    // stalls in the very cycle the timer is being loaded.
    always_comb begin
        w_stall_rs = operand_hazard(d_rs, d_tuse_rs, e_wreg, e_tnew, m_wreg, m_tnew);
        w_stall_rt = operand_hazard(d_rt, d_tuse_rt, e_wreg, e_tnew, m_wreg, m_tnew);
        w_stall_md = d_is_md && (md_busy || e_md_start);
        w_stall    = w_stall_rs || w_stall_rt || w_stall_md;
    end

    assign stall_f = w_stall;
    assign stall_d = w_stall;
    assign flush_e = w_stall;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (w_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stall_ctrl
// Description : Directed plus random bench for pipeline_stall_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  d_rs, d_rt, e_wreg, m_wreg;
    logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic        d_is_md, e_md_start, e_md_is_div;
    logic        stall_f, stall_d, flush_e, md_busy;
    logic [3:0]  md_count;
    logic [31:0] stall_cycles;

    int              total = 0;
    int              bad   = 0;
    int              m_rem = 0;
    longint unsigned m_sc  = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .d_rs         (d_rs),
        .d_rt         (d_rt),
        .d_tuse_rs    (d_tuse_rs),
        .d_tuse_rt    (d_tuse_rt),
        .d_is_md      (d_is_md),
        .e_wreg       (e_wreg),
        .m_wreg       (m_wreg),
        .e_tnew       (e_tnew),
        .m_tnew       (m_tnew),
        .e_md_start   (e_md_start),
        .e_md_is_div  (e_md_is_div),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_e      (flush_e),
        .md_busy      (md_busy),
        .md_count     (md_count),
        .stall_cycles (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit op_needs_wait(input logic [4:0] src, input logic [1:0] tuse);
        int need;
        need = int'(tuse);
        if (src == 5'd0 || need == 3) return 1'b0;
        if (src == e_wreg && int'(e_tnew) > need) return 1'b1;
        if (src == m_wreg && int'(m_tnew) > need) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit ref_stall();
        bit md_wait;
        md_wait = d_is_md && ((m_rem > 0) || e_md_start);
        return op_needs_wait(d_rs, d_tuse_rs) || op_needs_wait(d_rt, d_tuse_rt) || md_wait;
    endfunction

    task automatic idle_inputs();
        d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
        d_is_md = 1'b0; e_wreg = 5'd0; m_wreg = 5'd0; e_tnew = 2'd0; m_tnew = 2'd0;
        e_md_start = 1'b0; e_md_is_div = 1'b0;
    endtask

    // One clock: check combinational stall against the model, take the edge,
    // advance the model, then check the registered state.
    task automatic cycle();
        bit s;
        #1;
        s = ref_stall();
        chk("stall_f", 32'(stall_f), 32'(s));
        chk("stall_d", 32'(stall_d), 32'(s));
        chk("flush_e", 32'(flush_e), 32'(s));
        if (e_md_start) chk("md_start_while_busy", 32'(md_busy), 32'd0);
        @(posedge clk);
        if (e_md_start)     m_rem = e_md_is_div ? DIV_N : MULT_N;
        else if (m_rem > 0) m_rem--;
        if (s && m_sc != 64'hFFFF_FFFF) m_sc++;
        #1;
        chk("md_count", 32'(md_count), 32'(m_rem));
        chk("md_busy", 32'(md_busy), 32'(m_rem != 0));
        chk("stall_cycles", stall_cycles, m_sc[31:0]);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_md_count", 32'(md_count), 32'd0);
        chk("rst_md_busy", 32'(md_busy), 32'd0);
        chk("rst_stall_cycles", stall_cycles, 32'd0);
        chk("rst_stall", 32'(stall_f), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cycle();

        // Load-use, then producer moved to M
        e_wreg = 5'd8; e_tnew = 2'd2; d_rs = 5'd8; d_tuse_rs = 2'd1;
        #1 chk("load_use_e", 32'(stall_d), 32'd1);
        cycle();
        e_wreg = 5'd0; m_wreg = 5'd8; m_tnew = 2'd1;
        #1 chk("load_use_m", 32'(stall_d), 32'd0);
        cycle();

        idle_inputs();
        d_rs = 5'd0; e_wreg = 5'd0; e_tnew = 2'd2; d_tuse_rs = 2'd0;
        #1 chk("zero_src", 32'(stall_f), 32'd0);
        cycle();

        idle_inputs();
        d_rt = 5'd9; e_wreg = 5'd9; e_tnew = 2'd2; d_tuse_rt = 2'd3;
        #1 chk("unused_rt", 32'(flush_e), 32'd0);
        cycle();

        // Divide with a HI/LO user waiting in D, from a cleared counter
        idle_inputs();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        m_rem = 0; m_sc = 0;
        d_is_md = 1'b1; e_md_start = 1'b1; e_md_is_div = 1'b1;
        #1;
        chk("div_start_stall", 32'(stall_f), 32'd1);
        chk("div_start_busy", 32'(md_busy), 32'd0);
        cycle();
        e_md_start = 1'b0;
        for (int i = 0; i < DIV_N; i++) begin
            #1 chk("div_busy_stall", 32'(stall_d), 32'd1);
            chk("div_count", 32'(md_count), 32'(DIV_N - i));
            cycle();
        end
        #1;
        chk("div_release", 32'(stall_d), 32'd0);
        chk("div_count_end", 32'(md_count), 32'd0);
        chk("div_stall_cycles", stall_cycles, 32'd11);
        cycle();

        // Asynchronous reset in the middle of a divide
        idle_inputs();
        e_md_start = 1'b1; e_md_is_div = 1'b1;
        cycle();
        e_md_start = 1'b0;
        repeat (4) cycle();
        chk("mid_div_count", 32'(md_count), 32'd6);
        reset = 1'b1;
        #1;
        chk("async_rst_count", 32'(md_count), 32'd0);
        chk("async_rst_busy", 32'(md_busy), 32'd0);
        chk("async_rst_sc", stall_cycles, 32'd0);
        m_rem = 0; m_sc = 0;
        @(negedge clk);
        reset = 1'b0;
        cycle();

        // Saturation of the stall counter
        dut.stall_cycles_q <= 32'hFFFF_FFFE;
        m_sc = 64'hFFFF_FFFE;
        e_wreg = 5'd8; e_tnew = 2'd2; d_rs = 5'd8; d_tuse_rs = 2'd1;
        repeat (3) cycle();
        chk("saturate", stall_cycles, 32'hFFFF_FFFF);

        // Random traffic against the model
        idle_inputs();
        m_rem = 0; m_sc = 0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        for (int n = 0; n < 400; n++) begin
            d_rs        = 5'($urandom_range(0, 3));
            d_rt        = 5'($urandom_range(0, 3));
            d_tuse_rs   = 2'($urandom_range(0, 3));
            d_tuse_rt   = 2'($urandom_range(0, 3));
            e_wreg      = 5'($urandom_range(0, 3));
            m_wreg      = 5'($urandom_range(0, 3));
            e_tnew      = 2'($urandom_range(0, 3));
            m_tnew      = 2'($urandom_range(0, 3));
            d_is_md     = 1'($urandom_range(0, 1));
            e_md_is_div = 1'($urandom_range(0, 1));
            e_md_start  = (m_rem == 0) && ($urandom_range(0, 5) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
